// File: rtl/quad_seq_pkg.sv
// Shared types and constants for the quadratic_sequence sequencer.
package quad_seq_pkg;

  localparam int unsigned TERM_W = 5;
  localparam int unsigned RES_W  = 2;
  localparam int unsigned DOUT_W = 4;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_UNDR = 1;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StGap,
    StRd,
    StWait
  } state_e;

endpackage

// File: rtl/quad_seq_fifo.sv
// Term buffer: DEPTH x WIDTH FIFO with push, pop, flush and fill level.
module quad_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/quad_seq_controller.sv
// Replays buffered terms into the quadratic_sequence core, then reads and captures its result.
// Optional QSEQ_AUTORUN_EN: start a run automatically once TERMS terms are buffered.
module quad_seq_controller
  import quad_seq_pkg::*;
#(
  parameter int unsigned TERMS  = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned GAP    = 1,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_term_we,
  input  logic [TERM_W-1:0]      i_term_wdata,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_q_write_en,
  output logic [TERM_W-1:0]      o_q_data,
  output logic                   o_q_read_en,
  input  logic [RES_W-1:0]       i_q_result,
  input  logic [DOUT_W-1:0]      i_q_data,
  output logic [RES_W-1:0]       o_result,
  output logic [DOUT_W-1:0]      o_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [1:0]             o_err,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(TERMS + 1);

  state_e             r_state;
  state_e             w_state_d;
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_d;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_d;
  logic               r_write_en;
  logic               r_read_en;
  logic [TERM_W-1:0]  r_q_data;
  logic [RES_W-1:0]   r_result;
  logic [DOUT_W-1:0]  r_data;
  logic               r_busy;
  logic               r_done;
  logic               w_done_d;
  logic [1:0]         r_err;
  logic [1:0]         w_err_d;
  logic               w_capture;
  logic               w_go;
  logic               w_underrun;
  logic               w_start_req;
  logic               w_enough;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [TERM_W-1:0]  w_head;
  logic [CW-1:0]      w_count;

  assign w_enough = (w_count >= CW'(TERMS));
`ifdef QSEQ_AUTORUN_EN
  assign w_start_req = i_start || w_enough;
`else
  assign w_start_req = i_start;
`endif

  // A push coinciding with abort is discarded along with the flush.
  assign w_push = i_term_we && !w_full && !i_abort;
  assign w_pop  = (w_state_d == StWr);

  quad_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TERM_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_abort),
    .i_wdata (i_term_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_idx_d    = r_idx;
    w_capture  = 1'b0;
    w_go       = 1'b0;
    w_underrun = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start_req && w_enough) begin
          w_go      = 1'b1;
          w_state_d = StWr;
          w_idx_d   = '0;
        end else if (i_start) begin
          w_underrun = 1'b1;
        end
      end
      StWr: begin
        w_idx_d = r_idx + IDX_W'(1);
        w_cnt_d = '0;
        if (GAP > 0) begin
          w_state_d = StGap;
        end else if (r_idx == IDX_W'(TERMS - 1)) begin
          w_state_d = StRd;
        end
      end
      StGap: begin
        if (r_cnt == 3'(GAP - 1)) begin
          w_state_d = (r_idx == IDX_W'(TERMS)) ? StRd : StWr;
        end else begin
          w_cnt_d = r_cnt + 3'd1;
        end
      end
      StRd: begin
        w_state_d = StWait;
        w_cnt_d   = '0;
      end
      StWait: begin
        if (r_cnt == 3'(RD_LAT - 1)) begin
          w_capture = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 3'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (i_abort) begin
      w_state_d  = StIdle;
      w_capture  = 1'b0;
      w_go       = 1'b0;
      w_underrun = 1'b0;
    end
  end

  // Status: cleared when a run launches, then new events are OR-ed in; abort holds.
  always_comb begin
    w_err_d  = r_err;
    w_done_d = r_done;
    if (!i_abort) begin
      if (w_go) begin
        w_err_d  = '0;
        w_done_d = 1'b0;
      end
      if (i_term_we && w_full) w_err_d[ERR_OVF] = 1'b1;
      if (w_underrun)          w_err_d[ERR_UNDR] = 1'b1;
      if (w_capture)           w_done_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      r_q_data   <= '0;
      r_result   <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_idx      <= w_idx_d;
      r_write_en <= (w_state_d == StWr);
      r_read_en  <= (w_state_d == StRd);
      r_busy     <= (w_state_d != StIdle);
      r_done     <= w_done_d;
      r_err      <= w_err_d;
      if (w_pop) r_q_data <= w_head;
      if (w_capture) begin
        r_result <= i_q_result;
        r_data   <= i_q_data;
      end
    end
  end

  assign o_q_write_en = r_write_en;
  assign o_q_data     = r_q_data;
  assign o_q_read_en  = r_read_en;
  assign o_result     = r_result;
  assign o_data       = r_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_count      = w_count;

endmodule

// File: tb/tb_quad_seq_controller.sv
// Directed and randomized checks of quad_seq_controller against a queue-based reference model.
module tb_quad_seq_controller;

  localparam int TERMS  = 3;
  localparam int DEPTH  = 4;
  localparam int GAP    = 1;
  localparam int RD_LAT = 1;
  localparam int WR_SPAN = TERMS * (GAP + 1);
  localparam int BUSY_N  = WR_SPAN + 1 + RD_LAT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       term_we = 1'b0;
  logic [4:0] term_wdata = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       q_write_en;
  logic [4:0] q_data;
  logic       q_read_en;
  logic [1:0] q_result_in = '0;
  logic [3:0] q_data_in = '0;
  logic [1:0] result;
  logic [3:0] data;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [2:0] count;

  quad_seq_controller #(
    .TERMS  (TERMS),
    .DEPTH  (DEPTH),
    .GAP    (GAP),
    .RD_LAT (RD_LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_term_we    (term_we),
    .i_term_wdata (term_wdata),
    .i_start      (start),
    .i_abort      (abort),
    .o_q_write_en (q_write_en),
    .o_q_data     (q_data),
    .o_q_read_en  (q_read_en),
    .i_q_result   (q_result_in),
    .i_q_data     (q_data_in),
    .o_result     (result),
    .o_data       (data),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_count      (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [4:0] mq[$];
  logic [1:0] m_err = '0;
  logic       m_done = 1'b0;
  logic [1:0] m_res = '0;
  logic [3:0] m_dat = '0;
  logic [4:0] m_last = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] v);
    term_we = 1'b1;
    term_wdata = v;
    tick();
    term_we = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(v);
    else m_err[0] = 1'b1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_res"}, 32'(result), 32'(m_res));
    chk({tag, "_dat"}, 32'(data), 32'(m_dat));
  endtask

  // Full run: writes every GAP+1 cycles, read after the last gap, capture after RD_LAT.
  task automatic run(input bit use_start, input bit rand_core);
    logic       exp_we;
    logic [1:0] cap_r;
    logic [3:0] cap_d;
    cap_r = '0;
    cap_d = '0;
    if (use_start) start = 1'b1;
    tick();
    start = 1'b0;
    m_err = '0;
    m_done = 1'b0;
    for (int c = 1; c <= BUSY_N; c++) begin
      exp_we = (c <= WR_SPAN) && (((c - 1) % (GAP + 1)) == 0);
      if (exp_we) m_last = mq.pop_front();
      chk("run_we", 32'(q_write_en), 32'(exp_we));
      chk("run_rd", 32'(q_read_en), 32'(c == WR_SPAN + 1));
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_qdata", 32'(q_data), 32'(m_last));
      if (c == 1) chk("run_done_clr", 32'(done), 32'd0);
      q_result_in = rand_core ? 2'($urandom) : 2'd2;
      q_data_in   = rand_core ? 4'($urandom) : 4'hA;
      if (c == BUSY_N) begin
        cap_r = q_result_in;
        cap_d = q_data_in;
      end
      tick();
    end
    m_res = cap_r;
    m_dat = cap_d;
    m_done = 1'b1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_we", 32'(q_write_en), 32'd0);
    chk_status("end");
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_we", 32'(q_write_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_status("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed run from the reference sequence
    push(5'd3);
    push(5'h1F);
    push(5'd5);
    chk("pre_count", 32'(count), 32'd3);
    run(1'b1, 1'b0);

    // Underrun: two terms then start
    push(5'($urandom));
    push(5'($urandom));
    start = 1'b1;
    tick();
    start = 1'b0;
    m_err[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("undr_we", 32'(q_write_en), 32'd0);
      chk("undr_busy", 32'(busy), 32'd0);
      chk("undr_err", 32'(err), 32'(m_err));
      tick();
    end
    push(5'($urandom));
    run(1'b1, 1'b1);

    // Overflow: five pushes into four entries
    for (int i = 0; i < 5; i++) push(5'($urandom));
    chk_status("ovf");
    run(1'b1, 1'b1);

    // Abort in the gap after the second write, with a concurrent push
    push(5'($urandom));
    push(5'($urandom));
    start = 1'b1;
    tick();
    start = 1'b0;
    m_err = '0;
    m_done = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 1 || c == 3) m_last = mq.pop_front();
      chk("ab_we", 32'(q_write_en), 32'(c == 1 || c == 3));
      chk("ab_qdata", 32'(q_data), 32'(m_last));
      if (c < 4) tick();
    end
    abort = 1'b1;
    term_we = 1'b1;
    term_wdata = 5'd7;
    tick();
    abort = 1'b0;
    term_we = 1'b0;
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      chk("ab_we_off", 32'(q_write_en), 32'd0);
      chk("ab_rd_off", 32'(q_read_en), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_qdata_hold", 32'(q_data), 32'(m_last));
      tick();
    end
    chk_status("ab");

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(3, 5);
      for (int i = 0; i < n; i++) push(5'($urandom));
      chk_status("rnd_pre");
      run(1'b1, 1'b1);
    end

    // Asynchronous reset in cycle 4 of a run
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mq.delete();
    for (int i = 0; i < 3; i++) push(5'($urandom));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    m_err = '0;
    m_done = 1'b0;
    m_res = '0;
    m_dat = '0;
    m_last = '0;
    chk("arst_we", 32'(q_write_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_qdata", 32'(q_data), 32'd0);
    chk_status("arst");
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_we", 32'(q_write_en), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 3; i++) push(5'($urandom));
    run(1'b1, 1'b1);

    // Three pushes with no start
    for (int i = 0; i < 3; i++) push(5'($urandom));
`ifdef QSEQ_AUTORUN_EN
    run(1'b0, 1'b1);
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("noauto_we", 32'(q_write_en), 32'd0);
      chk("noauto_busy", 32'(busy), 32'd0);
    end
    chk_status("noauto");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
